// File: rtl/oam_dma_if.sv
// Bus bundle for oam_dma: CPU register port, DMA fetch port, primary OAM
// write port and the busy/halt flag. The slave modport is the DMA engine side.
interface oam_dma_if;
  logic [15:0] inter_mem_addr;
  logic [7:0]  inter_mem_din;
  logic        inter_mem_we;
  logic        v_blank;
  logic [15:0] dma_addr;
  logic        dma_req;
  logic        dma_ack;
  logic [7:0]  dma_din;
  logic [7:0]  prim_oam_addr;
  logic [15:0] prim_oam_dout;
  logic        prim_oam_en;
  logic        prim_oam_we;
  logic        busy;

  modport master (
    output inter_mem_addr, inter_mem_din, inter_mem_we, v_blank, dma_ack, dma_din,
    input  dma_addr, dma_req, prim_oam_addr, prim_oam_dout, prim_oam_en, prim_oam_we, busy
  );

  modport slave (
    input  inter_mem_addr, inter_mem_din, inter_mem_we, v_blank, dma_ack, dma_din,
    output dma_addr, dma_req, prim_oam_addr, prim_oam_dout, prim_oam_en, prim_oam_we, busy
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM loader: CPU byte-pair writes into primary OAM through a
// 4-register window, plus a page DMA that copies 2*OAM_WORDS bytes from CPU
// memory into OAM while halting the CPU via busy.
// Build option: define OAM_DMA_VBLANK_GATE_EN to hold a triggered DMA until
// v_blank is high; without it the DMA starts one cycle after the trigger.
module oam_dma #(
  parameter logic [15:0] BASE_ADDR = 16'h4040,
  parameter int unsigned OAM_WORDS = 192
) (
  input logic        clk,
  input logic        reset,
  oam_dma_if.slave   bus
);

  localparam logic [8:0] LAST_BYTE = 9'(2 * OAM_WORDS - 1);
  localparam logic [7:0] LAST_WORD = 8'(OAM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VB,
    REQ,
    WAIT_ACK,
    COMMIT,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  ptr;
  logic        phase;
  logic [7:0]  low_byte;
  logic [7:0]  high_byte;
  logic [7:0]  page;
  logic [8:0]  byte_cnt;
  logic [15:0] dma_addr_q;
  logic        dma_req_q;
  logic        busy_q;
  logic [7:0]  oam_addr_q;
  logic [15:0] oam_dout_q;
  logic        oam_we_q;
  logic        reg_hit;

  // CPU register write decoded against the 4-byte window
  always_comb begin
    reg_hit = bus.inter_mem_we && (bus.inter_mem_addr[15:2] == BASE_ADDR[15:2]);
  end

`ifndef OAM_DMA_VBLANK_GATE_EN
  logic unused_vblank;
  assign unused_vblank = bus.v_blank;
`endif

  // Register interface, DMA sequencer and the single-cycle OAM write pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      phase      <= 1'b0;
      low_byte   <= '0;
      high_byte  <= '0;
      page       <= '0;
      byte_cnt   <= '0;
      dma_addr_q <= '0;
      dma_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      oam_addr_q <= '0;
      oam_dout_q <= '0;
      oam_we_q   <= 1'b0;
    end else begin
      oam_we_q <= 1'b0;
      case (state)
        // CPU registers are only live here, so busy implicitly blocks them
        IDLE: begin
          if (reg_hit) begin
            case (bus.inter_mem_addr[1:0])
              2'd0: begin
                ptr   <= bus.inter_mem_din;
                phase <= 1'b0;
              end
              2'd1: begin
                if (!phase) begin
                  low_byte <= bus.inter_mem_din;
                  phase    <= 1'b1;
                end else begin
                  if (32'(ptr) < OAM_WORDS) begin
                    oam_we_q   <= 1'b1;
                    oam_addr_q <= ptr;
                    oam_dout_q <= {bus.inter_mem_din, low_byte};
                  end
                  ptr   <= (ptr == LAST_WORD) ? '0 : ptr + 8'd1;
                  phase <= 1'b0;
                end
              end
              2'd2: begin
                page     <= bus.inter_mem_din;
                byte_cnt <= '0;
                busy_q   <= 1'b1;
                state    <= WAIT_VB;
              end
              default: ;
            endcase
          end
        end
        WAIT_VB: begin
`ifdef OAM_DMA_VBLANK_GATE_EN
          if (bus.v_blank) state <= REQ;
`else
          state <= REQ;
`endif
        end
        REQ: begin
          dma_req_q  <= 1'b1;
          dma_addr_q <= {page, 8'h00} + {7'b0, byte_cnt};
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.dma_ack) begin
            dma_req_q <= 1'b0;
            if (!byte_cnt[0]) begin
              low_byte <= bus.dma_din;
              byte_cnt <= byte_cnt + 9'd1;
              state    <= REQ;
            end else begin
              high_byte <= bus.dma_din;
              state     <= COMMIT;
            end
          end
        end
        COMMIT: begin
          oam_we_q   <= 1'b1;
          oam_addr_q <= byte_cnt[8:1];
          oam_dout_q <= {high_byte, low_byte};
          byte_cnt   <= byte_cnt + 9'd1;
          state      <= (byte_cnt == LAST_BYTE) ? DONE : REQ;
        end
        DONE: begin
          busy_q <= 1'b0;
          ptr    <= '0;
          phase  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low combinationally during reset so an in-flight
  // write pulse or request cannot leak into the reset cycle itself
  assign bus.dma_addr      = reset ? '0 : dma_addr_q;
  assign bus.dma_req       = reset ? 1'b0 : dma_req_q;
  assign bus.busy          = reset ? 1'b0 : busy_q;
  assign bus.prim_oam_addr = reset ? '0 : oam_addr_q;
  assign bus.prim_oam_dout = reset ? '0 : oam_dout_q;
  assign bus.prim_oam_en   = reset ? 1'b0 : oam_we_q;
  assign bus.prim_oam_we   = reset ? 1'b0 : oam_we_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: register-write vector table, directed DMA
// scenarios and randomized CPU traffic against a word-level OAM write model.
module tb_oam_dma;
  localparam logic [15:0] BASE  = 16'h4040;
  localparam int unsigned WORDS = 192;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oam_dma_if bus ();

  oam_dma #(.BASE_ADDR(BASE), .OAM_WORDS(WORDS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:65535];
  logic [23:0] seen_q[$];
  logic [23:0] exp_q[$];
  int          ack_delay = 0;

  // reference model state: word pointer, byte phase, pending low byte
  logic [7:0] m_ptr;
  bit         m_ph;
  logic [7:0] m_lo;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          we;
    logic [7:0]  oa;
    logic [15:0] od;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_ptr = '0;
    m_ph  = 1'b0;
    m_lo  = '0;
  endfunction

  // CPU register write as seen by OAM: only window hits, DMA_PAGE excluded
  function automatic void m_write(input logic [15:0] a, input logic [7:0] d);
    if (a[15:2] != BASE[15:2]) return;
    if (a[1:0] == 2'd0) begin
      m_ptr = d;
      m_ph  = 1'b0;
    end else if (a[1:0] == 2'd1) begin
      if (!m_ph) begin
        m_lo = d;
        m_ph = 1'b1;
      end else begin
        if (int'(m_ptr) < int'(WORDS)) exp_q.push_back({m_ptr, d, m_lo});
        m_ptr = (int'(m_ptr) == int'(WORDS) - 1) ? 8'd0 : m_ptr + 8'd1;
        m_ph  = 1'b0;
      end
    end
  endfunction

  // Whole-page copy: word k = {mem[base+2k+1], mem[base+2k]}
  function automatic void m_dma(input logic [7:0] p);
    logic [15:0] a;
    for (int k = 0; k < int'(WORDS); k++) begin
      a = {p, 8'h00} + 16'(2 * k);
      exp_q.push_back({8'(k), mem[a + 16'd1], mem[a]});
    end
    m_ptr = '0;
    m_ph  = 1'b0;
  endfunction

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.inter_mem_addr = a;
    bus.inter_mem_din  = d;
    bus.inter_mem_we   = 1'b1;
    @(posedge clk); #1;
    bus.inter_mem_we   = 1'b0;
  endtask

  task automatic wait_busy_low(input string name, input int limit);
    int n = 0;
    while (bus.busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic cmp_q(input string name);
    int errs = 0;
    int first = 0;
    int n;
    @(posedge clk); #1;
    n = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
    chk({name, "_count"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) begin
      if (seen_q[i] !== exp_q[i]) begin
        if (errs == 0) first = i;
        errs++;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s_data: %0d words differ, first at %0d got %h expected %h",
               name, errs, first, seen_q[first], exp_q[first]);
    end
    seen_q.delete();
    exp_q.delete();
  endtask

  task automatic fill_page(input logic [7:0] p);
    logic [15:0] a;
    for (int i = 0; i < 2 * int'(WORDS); i++) begin
      a = {p, 8'h00} + 16'(i);
      mem[a] = 8'($urandom);
    end
  endtask

  // OAM write monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.prim_oam_we === 1'b1 || bus.prim_oam_en === 1'b1) begin
        chk("en_matches_we", 32'(bus.prim_oam_en), 32'(bus.prim_oam_we));
        if (bus.prim_oam_we === 1'b1) seen_q.push_back({bus.prim_oam_addr, bus.prim_oam_dout});
      end
    end
  end

  // CPU-memory responder: ack after ack_delay cycles of request
  initial begin
    int wcnt;
    wcnt = 0;
    bus.dma_ack = 1'b0;
    bus.dma_din = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.dma_ack) begin
        bus.dma_ack = 1'b0;
        wcnt = 0;
      end else if (bus.dma_req === 1'b1) begin
        if (wcnt >= ack_delay) begin
          bus.dma_ack = 1'b1;
          bus.dma_din = mem[bus.dma_addr];
        end else begin
          wcnt++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    int snap;
    logic [15:0] a0;
    logic [15:0] ra;
    logic [7:0]  rd;
    logic [7:0]  rp;

    bus.inter_mem_addr = '0;
    bus.inter_mem_din  = '0;
    bus.inter_mem_we   = 1'b0;
    bus.v_blank        = 1'b0;
    reset              = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    m_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dma_addr", 32'(bus.dma_addr), 32'd0);
    chk("rst_dma_req", 32'(bus.dma_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_oam_addr", 32'(bus.prim_oam_addr), 32'd0);
    chk("rst_oam_dout", 32'(bus.prim_oam_dout), 32'd0);
    chk("rst_oam_en", 32'(bus.prim_oam_en), 32'd0);
    chk("rst_oam_we", 32'(bus.prim_oam_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // register-write vectors: {addr, data, write expected, oam addr, oam data}
    tbl.push_back('{16'h4040, 8'h05, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h34, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h12, 1'b1, 8'h05, 16'h1234});
    tbl.push_back('{16'h4041, 8'hCD, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'hAB, 1'b1, 8'h06, 16'hABCD});
    tbl.push_back('{16'h4040, 8'hBF, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h11, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h22, 1'b1, 8'hBF, 16'h2211});
    tbl.push_back('{16'h4041, 8'h33, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h44, 1'b1, 8'h00, 16'h4433});
    tbl.push_back('{16'h4043, 8'h55, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h66, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4045, 8'h77, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h88, 1'b1, 8'h01, 16'h8866});
    tbl.push_back('{16'h4040, 8'hC8, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h01, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h02, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4040, 8'h07, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'h99, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4040, 8'h08, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'hAA, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'hBB, 1'b1, 8'h08, 16'hBBAA});
    tbl.push_back('{16'h4041, 8'hCC, 1'b0, 8'h00, 16'h0000});
    tbl.push_back('{16'h4041, 8'hDD, 1'b1, 8'h09, 16'hDDCC});

    for (int i = 0; i < tbl.size(); i++) begin
      cpu_wr(tbl[i].a, tbl[i].d);
      m_write(tbl[i].a, tbl[i].d);
      @(negedge clk);
      chk($sformatf("tbl%0d_we", i), 32'(bus.prim_oam_we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_addr", i), 32'(bus.prim_oam_addr), 32'(tbl[i].oa));
        chk($sformatf("tbl%0d_dout", i), 32'(bus.prim_oam_dout), 32'(tbl[i].od));
      end
    end
    cmp_q("tbl_sb");

    // page DMA from 0x0200 with identity memory and single-cycle ack latency
    bus.v_blank = 1'b1;
    cpu_wr(BASE + 16'd2, 8'h02);
    m_dma(8'h02);
    @(negedge clk);
    chk("dma1_busy_set", 32'(bus.busy), 32'd1);
    wait_busy_low("dma1_busy_fall", 3000);
    @(posedge clk); #1;
    chk("dma1_word0", (seen_q.size() > 0) ? 32'(seen_q[0]) : 32'hFFFF_FFFF, 32'h00_0100);
    chk("dma1_word191", (seen_q.size() > 191) ? 32'(seen_q[191]) : 32'hFFFF_FFFF, 32'hBF_7F7E);
    chk("dma1_last_addr", 32'(bus.dma_addr), 32'h037F);
    chk("dma1_req_idle", 32'(bus.dma_req), 32'd0);
    cmp_q("dma1");

    // pointer and phase restart at zero after a DMA
    cpu_wr(BASE + 16'd1, 8'h5A); m_write(BASE + 16'd1, 8'h5A);
    cpu_wr(BASE + 16'd1, 8'hA5); m_write(BASE + 16'd1, 8'hA5);
    @(negedge clk);
    chk("post_dma_we", 32'(bus.prim_oam_we), 32'd1);
    chk("post_dma_addr", 32'(bus.prim_oam_addr), 32'd0);
    chk("post_dma_dout", 32'(bus.prim_oam_dout), 32'hA55A);
    cmp_q("post_dma");

    // trigger outside vertical blank
    bus.v_blank = 1'b0;
    fill_page(8'h10);
    cpu_wr(BASE + 16'd2, 8'h10);
    m_dma(8'h10);
`ifdef OAM_DMA_VBLANK_GATE_EN
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.dma_req !== 1'b0) errs++;
    end
    chk("vb_hold_req_low", 32'(errs), 32'd0);
    @(posedge clk); #1;
    bus.v_blank = 1'b1;
`endif
    n = 0;
    while (bus.dma_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("vb_req_rise", 32'(bus.dma_req), 32'd1);
    wait_busy_low("vb_busy_fall", 3000);
    cmp_q("dma_vb");

    // slow ack: request held stable; CPU writes during busy ignored;
    // v_blank falling mid-transfer does not pause it
    bus.v_blank = 1'b1;
    fill_page(8'h33);
    fill_page(8'h55);
    ack_delay = 10;
    cpu_wr(BASE + 16'd2, 8'h33);
    m_dma(8'h33);
    n = 0;
    while (bus.dma_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_req_seen", 32'(bus.dma_req), 32'd1);
    a0 = bus.dma_addr;
    chk("hold_first_addr", 32'(a0), 32'h3300);
    bus.v_blank = 1'b0;
    errs = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.dma_req !== 1'b1 || bus.dma_addr !== a0) errs++;
    end
    chk("hold_stable", 32'(errs), 32'd0);
    cpu_wr(BASE + 16'd1, 8'hE1);
    cpu_wr(BASE + 16'd1, 8'hE2);
    cpu_wr(BASE, 8'h20);
    cpu_wr(BASE + 16'd2, 8'h55);
    ack_delay = 0;
    wait_busy_low("hold_busy_fall", 5000);
    cmp_q("dma_hold");

    // reset during DMA after 50 words
    bus.v_blank = 1'b1;
    fill_page(8'h80);
    cpu_wr(BASE + 16'd2, 8'h80);
    m_dma(8'h80);
    while (exp_q.size() > 50) void'(exp_q.pop_back());
    n = 0;
    while (seen_q.size() < 50 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_req", 32'(bus.dma_req), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_we", 32'(bus.prim_oam_we), 32'd0);
    snap = seen_q.size();
    chk("abort_words", 32'(snap), 32'd50);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    repeat (30) @(negedge clk);
    chk("abort_no_more_writes", 32'(seen_q.size()), 32'(snap));
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    cmp_q("abort_sb");

    // randomized register traffic with a page DMA per round
    for (int r = 0; r < 3; r++) begin
      ack_delay = int'($urandom_range(0, 3));
      for (int k = 0; k < 100; k++) begin
        n  = int'($urandom_range(0, 99));
        rd = 8'($urandom);
        if (n < 55) begin
          ra = BASE + 16'd1;
        end else if (n < 75) begin
          ra = BASE;
          if ($urandom_range(0, 1) == 0) rd = 8'(186 + $urandom_range(0, 10));
        end else if (n < 85) begin
          ra = BASE + 16'd3;
        end else begin
          ra = 16'($urandom);
          while (ra[15:2] == BASE[15:2]) ra = 16'($urandom);
        end
        cpu_wr(ra, rd);
        m_write(ra, rd);
      end
      rp = 8'($urandom);
      fill_page(rp);
      cpu_wr(BASE + 16'd2, rp);
      m_dma(rp);
      wait_busy_low($sformatf("rand%0d_busy_fall", r), 6000);
      cmp_q($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
